// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction fetch with request credits, in-order responses and a redirect-flushed queue (optional FETCH_PERF_EN adds perf counters)
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000),
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + OW;
  logic [ADDR_W-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0]     count;
  logic [OW-1:0]     outstanding, drop, out_next;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [SW-1:0]     credit;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              redirect, req_fire, rsp_drop, push, pop;
  assign redirect = branch | jump;
  assign target = branch ? branch_addr : jump_addr;
  // every live request owns a queue slot, so responses can never overflow the queue
  assign credit = SW'(count) + SW'(outstanding) - SW'(drop);
  assign mem_req_valid = !rst && !redirect && (outstanding < OW'(MAX_OUT)) && (credit < SW'(DEPTH));
  assign mem_req_addr = fetch_pc;
  assign req_fire = mem_req_valid & mem_req_ready;
  assign rsp_drop = mem_rsp_valid && (drop != '0);
  assign push = mem_rsp_valid && (drop == '0) && !redirect;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redirect;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_next = outstanding + OW'(req_fire) - OW'(mem_rsp_valid);
  // PC, credit and queue bookkeeping; a redirect flushes the queue and marks in-flight responses stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop     <= out_next;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        fetch_pc <= req_fire ? fetch_pc + ADDR_W'(4) : fetch_pc;
        rsp_pc   <= push ? rsp_pc + ADDR_W'(4) : rsp_pc;
        drop     <= drop - OW'(rsp_drop);
        count    <= count + CW'(push) - CW'(pop);
        wr_ptr   <= wr_ptr + PW'(push);
        rd_ptr   <= rd_ptr + PW'(pop);
      end
    end
  end
  // queue storage needs no reset: entries are only visible while count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= mem_rsp_data;
    end
  end
`ifdef FETCH_PERF_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, perf_flushed} + (redirect ? 33'(count) : 33'd0)
                     + 33'(mem_rsp_valid && (redirect || drop != '0));
  // saturating counters of delivered instructions and of work thrown away by redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= (pop && perf_fetched != '1) ? perf_fetched + 32'd1 : perf_fetched;
      perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: self-checking bench with a memory model and a queue-level reference of the fetch stream
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  logic clk = 0, rst = 0, branch = 0, jump = 0, mem_req_ready = 0, mem_rsp_valid = 0, out_ready = 0;
  logic mem_req_valid, out_valid;
  logic [31:0] branch_addr = 0, jump_addr = 0, mem_rsp_data = 0, mem_req_addr, out_pc, out_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { bit br; bit jp; logic [31:0] ba; logic [31:0] ja; logic [31:0] exp_addr; logic [31:0] exp_next; } vec_t;
  ent_t q[$];
  req_t pend[$];
  vec_t vecs[5];
  int tests = 0, fails = 0, cyc = 0, lat = 1, pops = 0, hs_cnt = 0;
  logic [31:0] exp_req = RST_PC, s_addr = 0, s_pc = 0;
  bit prev_redir = 0, s_ov = 0, s_hs = 0, s_pop = 0, s_rv = 0;

  if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    int stale = 0;
    bit redir, exp_rv;
    ent_t e;
    req_t r;
    @(negedge clk);
    mem_rsp_valid = 0;
    mem_rsp_data = 0;
    if (pend.size() != 0) begin
      if (pend[0].due <= cyc) begin
        mem_rsp_valid = 1;
        mem_rsp_data = inst_of(pend[0].addr);
      end
    end
    #1;
    redir = branch | jump;
    foreach (pend[i]) stale += int'(pend[i].stale);
    if (prev_redir) chk("empty_after_redirect", 32'(out_valid), 0);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_pc", out_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("out_inst", out_inst, q.size() != 0 ? q[0].inst : 32'h0);
    exp_rv = !redir && pend.size() < MAX_OUT && (q.size() + pend.size() - stale) < DEPTH;
    chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    chk("req_addr", mem_req_addr, exp_req);
    s_ov = out_valid; s_pc = out_pc; s_addr = mem_req_addr; s_rv = mem_req_valid;
    s_hs = mem_req_valid && mem_req_ready;
    s_pop = out_valid && out_ready && !redir;
    if (s_pop && q.size() != 0) begin e = q.pop_front(); pops++; end
    if (mem_rsp_valid) begin
      r = pend.pop_front();
      if (!r.stale && !redir) q.push_back('{r.addr, inst_of(r.addr)});
    end
    chk("queue_bound", 32'(q.size() <= DEPTH), 1);
    if (s_hs) begin
      pend.push_back('{mem_req_addr, cyc + lat, 1'b0});
      exp_req += 4;
      hs_cnt++;
    end
    if (redir) begin
      q.delete();
      foreach (pend[i]) pend[i].stale = 1;
      exp_req = branch ? branch_addr : jump_addr;
    end
    prev_redir = redir;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; branch = 0; jump = 0; mem_rsp_valid = 0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    q.delete(); pend.delete();
    exp_req = RST_PC; prev_redir = 0; pops = 0; hs_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, h0;
    vecs[0] = '{1'b1, 1'b0, 32'h0040_0100, 32'h0050_0000, 32'h0040_0100, 32'h0040_0104};
    vecs[1] = '{1'b0, 1'b1, 32'h0040_0100, 32'h0040_0300, 32'h0040_0300, 32'h0040_0304};
    vecs[2] = '{1'b1, 1'b1, 32'h0040_0200, 32'h0040_0300, 32'h0040_0200, 32'h0040_0204};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0010, 32'h0000_0010, 32'h0000_0014};
    #2;
    do_reset();
    // streaming from reset with a 1-cycle memory
    lat = 1; mem_req_ready = 1; out_ready = 1;
    step(); chk("first_hs", 32'(s_hs), 1); chk("first_addr", s_addr, RST_PC); chk("lat_c0", 32'(s_ov), 0);
    step(); chk("lat_c1", 32'(s_ov), 0);
    step(); chk("lat_c2", 32'(s_ov), 1); chk("first_pc", s_pc, RST_PC);
    p0 = pops;
    repeat (20) step();
    chk("throughput", 32'(pops - p0), 20);
    // decode stall fills the queue and stops requests
    do_reset();
    out_ready = 0;
    repeat (10) step();
    chk("stall_hs", 32'(hs_cnt), 4);
    chk("stall_req_valid", 32'(s_rv), 0);
    chk("stall_head", s_pc, RST_PC);
    out_ready = 1;
    repeat (10) step();
    // toggling memory ready
    h0 = hs_cnt;
    for (int i = 0; i < 20; i++) begin
      mem_req_ready = i[0];
      step();
    end
    chk("toggle_hs", 32'(hs_cnt - h0), 10);
    mem_req_ready = 1;
    // branch with two stale responses in flight on a 3-cycle memory
    do_reset();
    lat = 3;
    step(); step();
    chk("inflight_hs", 32'(hs_cnt), 2);
    branch = 1; branch_addr = 32'h0040_0100;
    step();
    branch = 0;
    chk("redirect_req_low", 32'(s_rv), 0);
    step();
    chk("flush_empty", 32'(s_ov), 0);
    for (int i = 0; i < 20 && !s_pop; i++) step();
    chk("branch_popped", 32'(s_pop), 1);
    chk("branch_target_pc", s_pc, 32'h0040_0100);
`ifdef FETCH_PERF_EN
    chk("perf_flushed", perf_flushed, 2);
    chk("perf_fetched", perf_fetched, 32'(pops));
`endif
    // redirect vectors: priority and address wrap
    do_reset();
    lat = 1;
    repeat (4) step();
    foreach (vecs[k]) begin
      branch = vecs[k].br; jump = vecs[k].jp;
      branch_addr = vecs[k].ba; jump_addr = vecs[k].ja;
      step();
      branch = 0; jump = 0;
      step();
      chk("vec_addr", s_addr, vecs[k].exp_addr);
      chk("vec_hs", 32'(s_hs), 1);
      step();
      chk("vec_next", s_addr, vecs[k].exp_next);
      repeat (3) step();
    end
    // asynchronous reset in the middle of fetching
    repeat (5) step();
    do_reset();
    step();
    chk("restart_addr", s_addr, RST_PC);
    chk("restart_hs", 32'(s_hs), 1);
    // randomized traffic against the reference model
    for (int p = 0; p < 6; p++) begin
      lat = $urandom_range(1, 4);
      repeat (300) begin
        mem_req_ready = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 3) != 0;
        branch = $urandom_range(0, 29) == 0;
        jump = $urandom_range(0, 29) == 0;
        branch_addr = $urandom() & 32'hFFFF_FFFC;
        jump_addr = $urandom() & 32'hFFFF_FFFC;
        step();
      end
      branch = 0; jump = 0;
      if (p == 2) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end, the successor to the PC/INST_MEM fetch stage.
- Decouples PC generation from instruction memory with a valid/ready request port and an in-order response port, so memory latency can be multi-cycle.
- Buffers fetched instructions in a DEPTH-entry queue that feeds decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
ADDR_W, 32, PC/address width in bits
DATA_W, 32, instruction width in bits
RESET_PC, 32'h0040_0000, first fetch address after reset
DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding memory requests (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
branch  in  1  redirect to branch_addr (highest priority)
jump  in  1  redirect to jump_addr
branch_addr  in  ADDR_W  branch target
jump_addr  in  ADDR_W  jump target
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  fetch address
mem_rsp_valid  in  1  response valid (in order, one per accepted request)
mem_rsp_data  in  DATA_W  instruction word
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head (low = stall)
out_pc  out  ADDR_W  PC of head instruction
out_inst  out  DATA_W  head instruction

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0.
  - mem_req_valid=0, out_valid=0, out_pc=0, out_inst=0.
  - Takes effect mid-operation immediately; all in-flight state is discarded.
- Request issue:
  - mem_req_valid=1 when outstanding < MAX_OUT and (count + outstanding − drop) < DEPTH; this credit rule guarantees no response can overflow the queue.
  - mem_req_addr=fetch_pc.
  - On handshake (valid & ready): fetch_pc += 4 (wraps modulo 2^ADDR_W); outstanding++.
  - The request is held stable while ready is low unless a redirect occurs.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If drop>0: data discarded, drop−−.
  - Otherwise {rsp_pc, data} is pushed to the queue tail. rsp_pc is tracked by a separate counter advanced on every non-dropped response.
- Output:
  - out_valid = queue non-empty; out_pc/out_inst = head.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are allowed when full: count is unchanged.
- Redirect (branch | jump):
  - Target = branch_addr if branch, else jump_addr.
  - Queue cleared same edge. fetch_pc = target; rsp_pc = target.
  - drop = outstanding after this cycle's request/response accounting, i.e. includes a request accepted this cycle and excludes a response arriving this cycle.
  - A pop coincident with a redirect is discarded.
  - mem_req_valid is forced low in the redirect cycle; fetching resumes at the target the next cycle.
- Latency: with a 1-cycle memory, the first out_valid after reset or redirect appears 2 cycles after the request handshake cycle.
- Throughput: one instruction per cycle with out_ready=1 and a sufficiently deep MAX_OUT.
- Counters: DEPTH and MAX_OUT counters are sized to clog2(max)+1 bits with no overflow; the credit rule guarantees bounds.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetched[31:0] (instructions popped to decode) and perf_flushed[31:0] (queue entries cleared plus responses dropped due to redirect).
  - Both reset to 0, saturate at all-ones, and are updated on the same edge as the event.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, 1-cycle memory, out_ready=1 -> mem_req_addr 0x00400000, 0x00400004, …; out_pc follows in order with matching out_inst; sustained 1 inst/cycle.
2. out_ready=0 for 10 cycles -> requests stop once count+outstanding reaches DEPTH=4; no queue overflow; head stays at 0x00400000 until out_ready=1.
3. mem_req_ready toggling 1/0 -> mem_req_addr held stable while ready=0; no address skipped or duplicated.
4. Branch to 0x00400100 with 2 responses in flight (3-cycle memory) -> both stale responses dropped; next out_pc=0x00400100; queue empty the cycle after the redirect.
5. branch and jump asserted together (0x00400200 vs 0x00400300) -> fetch resumes at 0x00400200; rst asserted mid-fetch -> outputs zero immediately; fetch restarts at RESET_PC.
6. With FETCH_PERF_EN defined, run scenario 4 -> perf_flushed equals queued entries plus 2; perf_fetched equals the count of popped instructions.
